// File: rtl/button_debouncer.sv
// button_debouncer: conditions one raw, bouncing push-button pin into a clean
// registered level, single-cycle press/release strobes and a press toggle.
// The pin is synchronized with two flops, then a four-state FSM requires a
// window of DEBOUNCE_CYCLES consecutive agreeing samples before accepting a
// new level. Every output comes straight from a flop.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic toggle
);

    typedef enum logic [1:0] {
        RELEASED      = 2'd0,
        CHECK_PRESS   = 2'd1,
        PRESSED       = 2'd2,
        CHECK_RELEASE = 2'd3
    } state_t;

    // Last count value of a stability window; reaching it with an agreeing
    // sample accepts the new level.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                 s1_r;
    logic                 s_r;
    state_t               state_r;
    state_t               state_nxt_s;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [CNT_WIDTH-1:0] cnt_nxt_s;
    logic                 at_last_s;
    logic                 level_nxt_s;
    logic                 press_nxt_s;
    logic                 release_nxt_s;
    logic                 toggle_nxt_s;

    assign at_last_s = (cnt_r == CNT_LAST);

    // Two-flop synchronizer for the asynchronous pin; only s_r is used past here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= 1'b0;
            s_r  <= 1'b0;
        end else begin
            s1_r <= button;
            s_r  <= s1_r;
        end
    end

    // State, stability counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= RELEASED;
            cnt_r       <= {CNT_WIDTH{1'b0}};
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            toggle      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            btn_level   <= level_nxt_s;
            btn_press   <= press_nxt_s;
            btn_release <= release_nxt_s;
            toggle      <= toggle_nxt_s;
        end
    end

    // Next-state and counter logic; a disagreeing sample aborts a window and
    // the counter is cleared on every entry to a CHECK state, so it never wraps.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            RELEASED: begin
                if (s_r) begin
                    state_nxt_s = CHECK_PRESS;
                    cnt_nxt_s   = {CNT_WIDTH{1'b0}};
                end else begin
                    state_nxt_s = RELEASED;
                end
            end
            CHECK_PRESS: begin
                if (!s_r) begin
                    state_nxt_s = RELEASED;
                end else if (at_last_s) begin
                    state_nxt_s = PRESSED;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!s_r) begin
                    state_nxt_s = CHECK_RELEASE;
                    cnt_nxt_s   = {CNT_WIDTH{1'b0}};
                end else begin
                    state_nxt_s = PRESSED;
                end
            end
            CHECK_RELEASE: begin
                if (s_r) begin
                    state_nxt_s = PRESSED;
                end else if (at_last_s) begin
                    state_nxt_s = RELEASED;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = RELEASED;
                cnt_nxt_s   = {CNT_WIDTH{1'b0}};
            end
        endcase
    end

    // Output values to be registered: strobes fire only on the accepting edge.
    always_comb begin
        press_nxt_s   = 1'b0;
        release_nxt_s = 1'b0;
        level_nxt_s   = 1'b0;
        if ((state_r == CHECK_PRESS) && s_r && at_last_s) begin
            press_nxt_s = 1'b1;
        end else begin
            press_nxt_s = 1'b0;
        end
        if ((state_r == CHECK_RELEASE) && !s_r && at_last_s) begin
            release_nxt_s = 1'b1;
        end else begin
            release_nxt_s = 1'b0;
        end
        if ((state_nxt_s == PRESSED) || (state_nxt_s == CHECK_RELEASE)) begin
            level_nxt_s = 1'b1;
        end else begin
            level_nxt_s = 1'b0;
        end
        toggle_nxt_s = toggle ^ press_nxt_s;
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Testbench for button_debouncer with DEBOUNCE_CYCLES = 4, CNT_WIDTH = 3.
// A reference model tracks the synchronizer as a two-sample delay and
// accepts a new level once a run of DEBOUNCE_CYCLES+1 synchronized samples
// disagrees with the current level.
module tb_button_debouncer;

    localparam int DC = 4;
    localparam int CW = 3;

    logic clk;
    logic rst_n;
    logic button;
    logic btn_level;
    logic btn_press;
    logic btn_release;
    logic toggle;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .button     (button),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .toggle     (toggle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // reference model state
    bit m_s1, m_s, m_level, m_toggle, m_press, m_rel;
    int m_run;

    // observed history
    int edge_n = 0;
    int press_cnt = 0;
    int rel_cnt = 0;
    int last_press_edge = -1;
    int last_rel_edge = -1;
    logic [2:0] tog_seq = 3'b000;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 1'b0; m_s = 1'b0; m_level = 1'b0; m_toggle = 1'b0;
        m_press = 1'b0; m_rel = 1'b0; m_run = 0;
    endtask

    task automatic model_edge(input bit b);
        bit s_old;
        s_old   = m_s;
        m_press = 1'b0;
        m_rel   = 1'b0;
        if (s_old != m_level) begin
            m_run++;
            if (m_run == DC + 1) begin
                m_level = s_old;
                m_run   = 0;
                if (s_old) begin
                    m_press  = 1'b1;
                    m_toggle = ~m_toggle;
                end else begin
                    m_rel = 1'b1;
                end
            end
        end else begin
            m_run = 0;
        end
        m_s  = m_s1;
        m_s1 = b;
    endtask

    task automatic edge_and_check();
        @(posedge clk);
        edge_n++;
        if (!rst_n) model_reset();
        else        model_edge(button);
        #1;
        check("outputs", int'({btn_level, btn_press, btn_release, toggle}),
              int'({m_level, m_press, m_rel, m_toggle}));
        check("strobe_excl", int'(btn_press & btn_release), 0);
        if (btn_press === 1'b1) begin
            press_cnt++;
            last_press_edge = edge_n;
            tog_seq = {tog_seq[1:0], toggle};
        end
        if (btn_release === 1'b1) begin
            rel_cnt++;
            last_rel_edge = edge_n;
        end
    endtask

    task automatic step(input bit b);
        @(negedge clk);
        button = b;
        edge_and_check();
    endtask

    task automatic hold(input bit b, input int n);
        for (int i = 0; i < n; i++) step(b);
    endtask

    // asynchronous reset asserted mid-cycle, outputs must clear before the next edge
    task automatic async_reset(input bit b);
        button = b;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_immediate", int'({btn_level, btn_press, btn_release, toggle}), 0);
        model_reset();
        hold(b, 2);
    endtask

    task automatic release_reset(input bit b);
        @(negedge clk);
        rst_n  = 1'b1;
        button = b;
        edge_and_check();
    endtask

    int mark;
    int base_p;
    int base_r;
    logic [3:0] pattern [9];

    initial begin
        rst_n  = 1'b0;
        button = 1'b0;
        model_reset();
        #1;
        rst_n = 1'b1;
        hold(1'b0, 4);

        // reset with button held, then release with button still pressed
        async_reset(1'b1);
        release_reset(1'b1);
        mark = edge_n;
        hold(1'b1, 8);
        check("held_at_reset_latency", last_press_edge - mark, DC + 2);
        check("held_at_reset_level", int'(btn_level), 1);
        check("held_at_reset_toggle", int'(toggle), 1);

        // clean press and release from a fresh reset
        async_reset(1'b0);
        release_reset(1'b0);
        hold(1'b0, 6);
        step(1'b1);
        mark = edge_n;
        hold(1'b1, 12);
        check("press_latency", last_press_edge - mark, DC + 2);
        check("press_toggle", int'(toggle), 1);
        step(1'b0);
        mark = edge_n;
        hold(1'b0, 12);
        check("release_latency", last_rel_edge - mark, DC + 2);
        check("release_toggle", int'(toggle), 1);
        check("release_level", int'(btn_level), 0);

        // bounce rejection
        pattern = '{4'd1, 4'd1, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd1, 4'd0};
        base_p = press_cnt;
        foreach (pattern[i]) step(pattern[i][0]);
        check("bounce_no_strobe", press_cnt - base_p, 0);
        step(1'b1);
        mark = edge_n;
        hold(1'b1, 12);
        check("bounce_one_press", press_cnt - base_p, 1);
        check("bounce_latency", last_press_edge - mark, DC + 2);

        // glitch while pressed
        base_r = rel_cnt;
        hold(1'b0, 3);
        hold(1'b1, 10);
        check("glitch_no_release", rel_cnt - base_r, 0);
        check("glitch_level", int'(btn_level), 1);
        hold(1'b0, 12);

        // reset in the middle of a press window
        base_p = press_cnt;
        hold(1'b1, 5);
        async_reset(1'b1);
        release_reset(1'b0);
        hold(1'b0, 15);
        check("midwindow_no_press", press_cnt - base_p, 0);

        // toggle sequence over three clean press/release pairs
        base_p = press_cnt;
        base_r = rel_cnt;
        tog_seq = 3'b000;
        for (int i = 0; i < 3; i++) begin
            hold(1'b1, 10);
            hold(1'b0, 10);
        end
        check("toggle_seq", int'(tog_seq), 5);
        check("toggle_presses", press_cnt - base_p, 3);
        check("toggle_releases", rel_cnt - base_r, 3);

        // randomized bouncing segments, checked cycle by cycle against the model
        for (int seg = 0; seg < 120; seg++) begin
            hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 8)));
        end
        hold(1'b0, 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Conditions one raw mechanical push-button input into a clean, glitch-free level plus single-cycle press and release strobes. It also provides a toggle output that flips on every debounced press. This is the input-side companion to the on-board LED output drivers. The block sits directly behind a board pin in the 100 MHz `clk` domain, and its outputs feed FSMs, counters or LEDs in the same domain.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable synchronized samples required to accept a new level (10 ms at 100 MHz). Legal range is 1 to 2^`CNT_WIDTH` − 1.
- `CNT_WIDTH`, default 20: width of the stability counter.
- `clk`  in  1  100 MHz system clock; all flops are clocked on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low. Deassertion is synchronized externally.
- `button`  in  1  raw pin, asynchronous to `clk`, bouncing; 1 = pressed.
- `btn_level`  out  1  debounced button level, registered.
- `btn_press`  out  1  one-cycle strobe on an accepted 0→1 transition, registered.
- `btn_release`  out  1  one-cycle strobe on an accepted 1→0 transition, registered.
- `toggle`  out  1  flips on each `btn_press`, registered.

## Operation
- Synchronizer: two flops, `button` → `s1` → `s`. Both reset to 0. Only `s` is used downstream.
- FSM states and counter `cnt` (`CNT_WIDTH` bits):
  - RELEASED: `btn_level` = 0.
    - `s` = 1 → go to CHECK_PRESS with `cnt` ← 0.
  - CHECK_PRESS: `btn_level` = 0.
    - `s` = 0 → return to RELEASED. This is bounce rejection; no output change.
    - `s` = 1 and `cnt` = `DEBOUNCE_CYCLES`−1 → go to PRESSED. On the same edge: `btn_level` ← 1, `btn_press` ← 1, `toggle` inverts.
    - Otherwise `cnt` ← `cnt`+1.
  - PRESSED: `btn_level` = 1.
    - `s` = 0 → go to CHECK_RELEASE with `cnt` ← 0.
  - CHECK_RELEASE: `btn_level` = 1.
    - `s` = 1 → return to PRESSED.
    - `s` = 0 and `cnt` = `DEBOUNCE_CYCLES`−1 → go to RELEASED. On the same edge: `btn_level` ← 0, `btn_release` ← 1. `toggle` is unchanged.
    - Otherwise `cnt` ← `cnt`+1.
- `btn_press` and `btn_release` are 0 in every cycle except the single transition edge. They are never 1 simultaneously.
- `cnt` never wraps. It is cleared on every entry to a CHECK state, and its maximum value is `DEBOUNCE_CYCLES`−1.
- Any single disagreeing sample in a CHECK state aborts the window. A new window restarts from `cnt` = 0 on the next qualifying sample.
- Reset (async, `rst_n` = 0):
  - Effect: state ← RELEASED, `cnt` ← 0, `s1` ← 0, `s` ← 0, all outputs ← 0. This takes effect immediately, without waiting for a clock edge.
  - Reset mid-CHECK: the partial window is discarded and no strobe is ever emitted for it.
  - Button held at reset release: this is treated as a fresh press and produces a full-latency `btn_press` strobe.

## Timing
- Let edge k be the first rising edge at which `button` is sampled at a new stable value:
  - `s` changes after edge k+1.
  - The FSM enters CHECK after edge k+2.
  - Outputs update after edge k+`DEBOUNCE_CYCLES`+2.
- Latency is therefore `DEBOUNCE_CYCLES`+2 edges after the first sample, identical for press and release. With `DEBOUNCE_CYCLES` = 1 it is 3 edges.
- Strobe width is exactly one `clk` period.
- Minimum interval between `btn_press` and the following `btn_release` is `DEBOUNCE_CYCLES`+1 cycles.
- Pulses on `button` shorter than `DEBOUNCE_CYCLES` cycles (after synchronization) never change `btn_level`.
- No combinational path from any input to any output.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4 and `CNT_WIDTH` = 3.
- Reset:
  - Stimulus: `rst_n` = 0 asynchronously mid-cycle while `button` = 1.
  - Response: all outputs are 0 before the next edge.
  - Stimulus: release `rst_n` with `button` still 1.
  - Response: `btn_press` = 1 for one cycle, 6 edges after the first sampling edge; `btn_level` = 1; `toggle` = 1.
- Clean press and release:
  - Stimulus: `button` 0→1, sampled at edge 10, then held.
  - Response: after edge 16, `btn_press` = 1 for one cycle, `btn_level` = 1, `toggle` 0→1.
  - Stimulus: `button` 1→0, sampled at edge 30.
  - Response: after edge 36, `btn_release` = 1 for one cycle, `btn_level` = 0, `toggle` stays 1.
- Bounce rejection:
  - Stimulus: `button` pattern 1,1,1,0,1,0,1,1,0 (one cycle each), then held 1.
  - Response: no strobe during the pattern. Exactly one `btn_press` arrives 6 edges after the first sample of the final stable 1.
- Glitch while pressed:
  - Stimulus: `btn_level` = 1, then `button` = 0 for 3 cycles, then back to 1.
  - Response: `btn_level` stays 1; `btn_release` never asserts.
- Reset mid-window:
  - Stimulus: assert `rst_n` = 0 while in CHECK_PRESS with `cnt` = 2, then release with `button` = 0.
  - Response: outputs are 0 immediately; no `btn_press` ever follows.
- Toggle sequence:
  - Stimulus: 3 clean presses, each followed by a clean release.
  - Response: `toggle` sequence is 1,0,1. There are exactly 3 `btn_press` and 3 `btn_release` strobes.
